// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM states, IF/ID word layout
// and the reset-time defaults used by the fetch front end.
package cpu_pkg;

   localparam logic [31:0] DEF_RESET_PC  = 32'h0000_0000;
   localparam logic [31:0] DEF_NOP_INSTR = 32'h0000_0000;

   typedef enum logic {
      FETCH = 1'b0,
      HOLD  = 1'b1
   } fetch_state_e;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc4;
   } fetch_word_t;

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry skid buffer parking a fetched word while decode
// is stalled; clear wins over load.
module fetch_skid_buffer
   import cpu_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        load_i,
   input  logic        clear_i,
   input  fetch_word_t data_i,
   output fetch_word_t data_o,
   output logic        valid_o
);

   fetch_word_t data_q;
   logic        valid_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_q  <= '0;
         valid_q <= 1'b0;
      end else if (clear_i) begin
         data_q  <= '0;
         valid_q <= 1'b0;
      end else if (load_i) begin
         data_q  <= data_i;
         valid_q <= 1'b1;
      end
   end

   assign data_o  = data_q;
   assign valid_o = valid_q;

endmodule

// File: rtl/fetch_pipeline_ctrl.sv
// Fetch stage: PC, instruction-memory request and the IF/ID
// register with load-use stall, flush redirect and skid buffer.
module fetch_pipeline_ctrl
   import cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = DEF_RESET_PC,
   parameter logic [31:0] NOP_INSTR = DEF_NOP_INSTR
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        load_enable,
   input  logic        flush,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic [31:0] fd_instruction,
   output logic [31:0] fd_pc_plus4,
   output logic        fd_valid
);

   fetch_state_e state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   fetch_word_t  fd_q, fd_d;
   logic         fd_valid_q, fd_valid_d;

   logic         skid_load, skid_clear, skid_valid;
   fetch_word_t  skid_in, skid_out;
   logic [31:0]  pc_plus4;
   logic         unused_redirect_lsb;

   assign pc_plus4            = pc_q + 32'd4;
   assign skid_in             = '{instr: imem_rdata, pc4: pc_plus4};
   assign unused_redirect_lsb = ^redirect_pc[1:0];

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      fd_d       = fd_q;
      fd_valid_d = fd_valid_q;
      skid_load  = 1'b0;
      skid_clear = 1'b0;
      if (flush) begin
         // Redirect beats stall and memory response alike
         fd_d.instr = NOP_INSTR;
         fd_valid_d = 1'b0;
         pc_d       = {redirect_pc[31:2], 2'b00};
         skid_clear = 1'b1;
         state_d    = FETCH;
      end else begin
         unique case (state_q)
            FETCH: begin
               if (load_enable) begin
                  if (imem_ready) begin
                     fd_d       = skid_in;
                     fd_valid_d = 1'b1;
                     pc_d       = pc_plus4;
                  end else begin
                     fd_d.instr = NOP_INSTR;
                     fd_valid_d = 1'b0;
                  end
               end else if (imem_ready) begin
                  skid_load = 1'b1;
                  state_d   = HOLD;
               end
            end
            HOLD: begin
               if (load_enable) begin
                  fd_d       = skid_out;
                  fd_valid_d = skid_valid;
                  pc_d       = pc_plus4;
                  skid_clear = 1'b1;
                  state_d    = FETCH;
               end
            end
            default: state_d = FETCH;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= FETCH;
         pc_q       <= RESET_PC;
         fd_q       <= '{instr: NOP_INSTR, pc4: 32'h0};
         fd_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         fd_q       <= fd_d;
         fd_valid_q <= fd_valid_d;
      end
   end

   fetch_skid_buffer u_skid (
      .clk     (clk),
      .rst     (rst),
      .load_i  (skid_load),
      .clear_i (skid_clear),
      .data_i  (skid_in),
      .data_o  (skid_out),
      .valid_o (skid_valid)
   );

   // Request is masked during reset so it rises right after release
   assign imem_req       = (state_q == FETCH) && !rst;
   assign imem_addr      = pc_q;
   assign fd_instruction = fd_q.instr;
   assign fd_pc_plus4    = fd_q.pc4;
   assign fd_valid       = fd_valid_q;

endmodule

// File: tb/tb_fetch_pipeline_ctrl.sv
// Bench for fetch_pipeline_ctrl: vector table driven through a
// scoreboard queue, plus an asynchronous reset during HOLD.
module tb_fetch_pipeline_ctrl;

   localparam logic [31:0] NOP = 32'h0000_0013;
   localparam logic [31:0] KEY = 32'hA5A5_A5A5;
   localparam int          NV  = 21;

   logic        clk;
   logic        rst;
   logic        load_enable;
   logic        flush;
   logic [31:0] redirect_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic [31:0] fd_instruction;
   logic [31:0] fd_pc_plus4;
   logic        fd_valid;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic        le;
      logic        fl;
      logic [31:0] rd;
      logic        rdy;
      logic        ereq;
      logic [31:0] eaddr;
      logic        ev;
      logic [31:0] ei;
      logic [31:0] ep;
      logic        cp;
   } vec_t;

   typedef struct {
      logic        ev;
      logic [31:0] ei;
      logic [31:0] ep;
      logic        cp;
   } exp_t;

   vec_t vecs [NV];
   exp_t sb [$];

   fetch_pipeline_ctrl #(
      .RESET_PC  (32'h0000_0000),
      .NOP_INSTR (NOP)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .load_enable    (load_enable),
      .flush          (flush),
      .redirect_pc    (redirect_pc),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_ready     (imem_ready),
      .imem_rdata     (imem_rdata),
      .fd_instruction (fd_instruction),
      .fd_pc_plus4    (fd_pc_plus4),
      .fd_valid       (fd_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign imem_rdata = imem_addr ^ KEY;

   function automatic logic [31:0] d(input logic [31:0] a);
      return a ^ KEY;
   endfunction

   function automatic vec_t mk(
      input logic le, input logic fl, input logic [31:0] rd,
      input logic rdy, input logic ereq, input logic [31:0] eaddr,
      input logic ev, input logic [31:0] ei, input logic [31:0] ep,
      input logic cp);
      vec_t v;
      v.le = le; v.fl = fl; v.rd = rd; v.rdy = rdy;
      v.ereq = ereq; v.eaddr = eaddr;
      v.ev = ev; v.ei = ei; v.ep = ep; v.cp = cp;
      return v;
   endfunction

   task automatic chk(input string n, input logic [31:0] act,
                      input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h want %h", n, act, exp);
      end
   endtask

   task automatic step(input vec_t v, input string tag);
      exp_t e;
      load_enable = v.le;
      flush       = v.fl;
      redirect_pc = v.rd;
      imem_ready  = v.rdy;
      #1;
      chk({tag, ".req"}, {31'b0, imem_req}, {31'b0, v.ereq});
      chk({tag, ".addr"}, imem_addr, v.eaddr);
      sb.push_back('{ev: v.ev, ei: v.ei, ep: v.ep, cp: v.cp});
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk({tag, ".valid"}, {31'b0, fd_valid}, {31'b0, e.ev});
      chk({tag, ".instr"}, fd_instruction, e.ei);
      if (e.cp) chk({tag, ".pc4"}, fd_pc_plus4, e.ep);
      @(negedge clk);
   endtask

   initial begin
      //          le fl rd            rdy req addr          v  instr            pc4           cp
      vecs[0]  = mk(1, 0, 32'h0,        1, 1, 32'h0,        1, d(32'h0),        32'h4,        1);
      vecs[1]  = mk(1, 0, 32'h0,        1, 1, 32'h4,        1, d(32'h4),        32'h8,        1);
      vecs[2]  = mk(1, 0, 32'h0,        0, 1, 32'h8,        0, NOP,             32'h8,        1);
      vecs[3]  = mk(1, 0, 32'h0,        0, 1, 32'h8,        0, NOP,             32'h8,        1);
      vecs[4]  = mk(1, 0, 32'h0,        0, 1, 32'h8,        0, NOP,             32'h8,        1);
      vecs[5]  = mk(1, 0, 32'h0,        1, 1, 32'h8,        1, d(32'h8),        32'hC,        1);
      vecs[6]  = mk(0, 0, 32'h0,        1, 1, 32'hC,        1, d(32'h8),        32'hC,        1);
      vecs[7]  = mk(0, 0, 32'h0,        1, 0, 32'hC,        1, d(32'h8),        32'hC,        1);
      vecs[8]  = mk(1, 0, 32'h0,        0, 0, 32'hC,        1, d(32'hC),        32'h10,       1);
      vecs[9]  = mk(1, 0, 32'h0,        1, 1, 32'h10,       1, d(32'h10),       32'h14,       1);
      vecs[10] = mk(0, 1, 32'h100,      1, 1, 32'h14,       0, NOP,             32'h0,        0);
      vecs[11] = mk(1, 0, 32'h0,        1, 1, 32'h100,      1, d(32'h100),      32'h104,      1);
      vecs[12] = mk(1, 1, 32'hFFFFFFFC, 1, 1, 32'h104,      0, NOP,             32'h0,        0);
      vecs[13] = mk(1, 0, 32'h0,        1, 1, 32'hFFFFFFFC, 1, d(32'hFFFFFFFC), 32'h0,        1);
      vecs[14] = mk(1, 0, 32'h0,        1, 1, 32'h0,        1, d(32'h0),        32'h4,        1);
      vecs[15] = mk(1, 1, 32'h103,      1, 1, 32'h4,        0, NOP,             32'h0,        0);
      vecs[16] = mk(1, 0, 32'h0,        1, 1, 32'h100,      1, d(32'h100),      32'h104,      1);
      vecs[17] = mk(0, 0, 32'h0,        1, 1, 32'h104,      1, d(32'h100),      32'h104,      1);
      vecs[18] = mk(0, 1, 32'h200,      1, 0, 32'h104,      0, NOP,             32'h0,        0);
      vecs[19] = mk(0, 0, 32'h0,        0, 1, 32'h200,      0, NOP,             32'h0,        0);
      vecs[20] = mk(1, 0, 32'h0,        1, 1, 32'h200,      1, d(32'h200),      32'h204,      1);

      rst         = 1'b1;
      load_enable = 1'b1;
      flush       = 1'b0;
      redirect_pc = 32'h0;
      imem_ready  = 1'b1;
      #2;
      chk("rst.req",   {31'b0, imem_req}, 32'h0);
      chk("rst.addr",  imem_addr, 32'h0);
      chk("rst.instr", fd_instruction, NOP);
      chk("rst.pc4",   fd_pc_plus4, 32'h0);
      chk("rst.valid", {31'b0, fd_valid}, 32'h0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < NV; i++)
         step(vecs[i], $sformatf("v%0d", i));

      // Enter HOLD, then hit reset asynchronously mid-cycle
      step(mk(0, 0, 32'h0, 1, 1, 32'h204, 1, d(32'h200), 32'h204, 1),
           "hold");
      #2 rst = 1'b1;
      #1;
      chk("arst.req",   {31'b0, imem_req}, 32'h0);
      chk("arst.addr",  imem_addr, 32'h0);
      chk("arst.instr", fd_instruction, NOP);
      chk("arst.pc4",   fd_pc_plus4, 32'h0);
      chk("arst.valid", {31'b0, fd_valid}, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      step(mk(1, 0, 32'h0, 1, 1, 32'h0, 1, d(32'h0), 32'h4, 1), "post");
      step(mk(1, 0, 32'h0, 1, 1, 32'h4, 1, d(32'h4), 32'h8, 1), "post2");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/fetch_pipeline_ctrl.md
FETCH_PIPELINE_CTRL -- requirements
Module: fetch_pipeline_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0000, bubble instruction written into the IF/ID register.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 load_enable  input  1  1 = pipeline may advance; 0 = load-use stall, hold IF/ID and PC.
REQ-006 flush  input  1  1 = taken branch/jump; discard fetched instruction, redirect PC.
REQ-007 redirect_pc  input  32  branch/jump target, sampled when flush=1.
REQ-008 imem_req  output  1  instruction-memory read request.
REQ-009 imem_addr  output  32  word-aligned fetch address, equal to current PC.
REQ-010 imem_ready  input  1  read data valid this cycle, meaningful only while imem_req=1.
REQ-011 imem_rdata  input  32  instruction word returned by memory.
REQ-012 fd_instruction  output  32  IF/ID register: instruction presented to decode.
REQ-013 fd_pc_plus4  output  32  IF/ID register: fetch PC + 4 of fd_instruction.
REQ-014 fd_valid  output  1  1 = fd_instruction is a real instruction; 0 = bubble.

Function
REQ-015 The FSM SHALL have states FETCH (imem_req=1) and HOLD (imem_req=0, fetched word parked in skid buffer).
REQ-016 In FETCH with imem_ready=1, load_enable=1, flush=0: IF/ID <= {imem_rdata, pc+4, valid=1}; pc <= pc+4; stay in FETCH.
REQ-017 In FETCH with imem_ready=0, load_enable=1, flush=0: IF/ID <= {NOP_INSTR, fd_pc_plus4 unchanged, valid=0}; pc holds.
REQ-018 In FETCH with load_enable=0, flush=0: IF/ID holds; if imem_ready=1, skid <= {imem_rdata, pc+4}, go to HOLD; else pc holds and stay in FETCH.
REQ-019 In HOLD with load_enable=1, flush=0: IF/ID <= skid contents with valid=1; pc <= pc+4; go to FETCH.
REQ-020 In HOLD with load_enable=0, flush=0: IF/ID, skid and pc hold; stay in HOLD.
REQ-021 flush=1 in any state SHALL take priority over load_enable and imem_ready: IF/ID <= {NOP_INSTR, valid=0}; pc <= redirect_pc; skid invalidated; next state FETCH; same-cycle imem_rdata discarded.
REQ-022 imem_addr SHALL be combinationally equal to pc; imem_req SHALL be 1 exactly in FETCH.
REQ-023 PC arithmetic SHALL be modulo 2^32: pc=32'hFFFF_FFFC advances to 32'h0000_0000.
REQ-024 redirect_pc[1:0] SHALL be ignored, so the PC is always word-aligned.
REQ-025 Each returned instruction SHALL reach IF/ID exactly once, in order, unless discarded by flush.

Reset
REQ-026 While rst=1: pc=RESET_PC, state=FETCH, fd_instruction=NOP_INSTR, fd_pc_plus4=0, fd_valid=0, skid cleared.
REQ-027 imem_req SHALL be 0 while rst=1 and SHALL rise in the first cycle after rst deasserts.
REQ-028 Reset asserted mid-HOLD or mid-fetch SHALL discard all in-flight state without waiting for imem_ready.

Structure
REQ-029 NOP_INSTR, RESET_PC default and the state enum {FETCH, HOLD} SHALL live in shared package cpu_pkg.
REQ-030 The skid buffer SHALL be sub-module fetch_skid_buffer: 32-bit instruction, 32-bit pc+4, valid bit, load/clear controls.

Verification
REQ-031 Reset release, imem_ready=1 every cycle with rdata=addr^32'hA5A5A5A5 -> imem_addr 0,4,8,... one per cycle; fd_valid=1 from cycle 2.
REQ-032 imem_ready=0 for 3 cycles at pc=8 -> 3 bubbles (fd_valid=0, fd_instruction=NOP_INSTR); imem_addr stays 8.
REQ-033 load_enable=0 for 2 cycles while imem_ready=1 at pc=12 -> IF/ID holds pc+4=12 word; HOLD entered, imem_req=0; on release fd_pc_plus4=16, next imem_addr=16.
REQ-034 flush=1, redirect_pc=32'h100, load_enable=0, imem_ready=1 same cycle -> fd_valid=0 next cycle, imem_addr=32'h100, returned data discarded.
REQ-035 Start at pc=32'hFFFF_FFFC -> next imem_addr=32'h0; redirect_pc=32'h103 -> imem_addr=32'h100.
REQ-036 rst asserted during HOLD -> outputs immediately at REQ-026 values; after release first fetch from RESET_PC.
